// File: rtl/addsub_seq_pkg.sv
// Shared types, default sizes and overflow helper for the multi-byte add/subtract sequencer.
package addsub_seq_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NBYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Signed overflow: the effective operands agree in sign but the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic sub, input logic sum_msb);
    logic beff_msb;
    beff_msb = b_msb ^ sub;
    return (a_msb == beff_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_out_reg.sv
// One-entry result holding register: data, last marker and word flags behind a valid/ready handshake.
// Flags load only on the final byte and then hold until overwritten by the next word.
module addsub_out_reg
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int FLAGS_W = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_flag_load,
  input  logic [WIDTH-1:0]   i_dat,
  input  logic               i_last,
  input  logic [FLAGS_W-1:0] i_flags,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_dat,
  output logic               o_last,
  output logic [FLAGS_W-1:0] o_flags
);

  logic               valid_q;
  logic [WIDTH-1:0]   dat_q;
  logic               last_q;
  logic [FLAGS_W-1:0] flags_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      dat_q   <= '0;
      last_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      if (i_load) begin
        valid_q <= 1'b1;
        dat_q   <= i_dat;
        last_q  <= i_last;
      end else if (i_ready) begin
        valid_q <= 1'b0;
      end
      if (i_flag_load) begin
        flags_q <= i_flags;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_dat   = dat_q;
  assign o_last  = last_q;
  assign o_flags = flags_q;

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Multi-byte add/subtract sequencer driving an external 8-bit Add_Sub stage, LSB byte first.
// Define ADDSUB_SEQ_FLAGS_EN to build the signed-overflow and zero flags; otherwise they read 0.
module addsub_seq_ctrl
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NBYTES = DEF_NBYTES
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_add_sub,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_a_byte,
  input  logic [WIDTH-1:0] i_b_byte,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_cin,
  output logic             o_add_sub,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_cout,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_sum_byte,
  output logic             o_last,
  input  logic             i_ready,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero,
  output logic             o_busy
);

`ifdef ADDSUB_SEQ_FLAGS_EN
  localparam int FLAGS_W = 3;
`else
  localparam int FLAGS_W = 1;
`endif
  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               mode_q;
  logic               busy_q;
  logic               out_vld;
  logic               out_last;
  logic               accept;
  logic               last_byte;
  logic [FLAGS_W-1:0] flags_d;
  logic [FLAGS_W-1:0] flags_q;

  assign o_ready   = (state_q == ST_RUN) && (!out_vld || i_ready);
  assign accept    = i_valid && o_ready;
  assign last_byte = (cnt_q == LAST_IDX);

  assign o_a       = i_a_byte;
  assign o_b       = i_b_byte;
  assign o_cin     = carry_q;
  assign o_add_sub = mode_q;
  assign o_busy    = busy_q;

`ifdef ADDSUB_SEQ_FLAGS_EN
  logic zacc_q;

  assign flags_d = {i_cout,
                    signed_ovf(i_a_byte[WIDTH-1], i_b_byte[WIDTH-1], mode_q, i_sum[WIDTH-1]),
                    zacc_q && (i_sum == '0)};
  assign o_cout  = flags_q[2];
  assign o_ovf   = flags_q[1];
  assign o_zero  = flags_q[0];
`else
  assign flags_d = i_cout;
  assign o_cout  = flags_q[0];
  assign o_ovf   = 1'b0;
  assign o_zero  = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ADDSUB_SEQ_FLAGS_EN
      zacc_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q <= ST_RUN;
            mode_q  <= i_add_sub;
            cnt_q   <= '0;
            // Subtract seeds carry-in with 1 to form the two's complement of B.
            carry_q <= i_add_sub;
            busy_q  <= 1'b1;
`ifdef ADDSUB_SEQ_FLAGS_EN
            zacc_q  <= 1'b1;
`endif
          end
        end
        ST_RUN: begin
          if (accept) begin
            carry_q <= i_cout;
            cnt_q   <= cnt_q + CNT_W'(1);
`ifdef ADDSUB_SEQ_FLAGS_EN
            zacc_q  <= zacc_q && (i_sum == '0);
`endif
            if (last_byte) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_vld && i_ready && out_last) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  addsub_out_reg #(
    .WIDTH   (WIDTH),
    .FLAGS_W (FLAGS_W)
  ) u_out_reg (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (accept),
    .i_flag_load (accept && last_byte),
    .i_dat       (i_sum),
    .i_last      (last_byte),
    .i_flags     (flags_d),
    .i_ready     (i_ready),
    .o_valid     (out_vld),
    .o_dat       (o_sum_byte),
    .o_last      (out_last),
    .o_flags     (flags_q)
  );

  assign o_valid = out_vld;
  assign o_last  = out_last;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl with a behavioural model of the external Add_Sub stage.
module tb_addsub_seq_ctrl;

  localparam int W  = 8;
  localparam int NB = 4;
`ifdef ADDSUB_SEQ_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct {
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [W-1:0] dat;
    logic         last;
  } sb_t;

  logic         clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic         i_add_sub = 1'b0;
  logic         i_valid = 1'b0;
  logic [W-1:0] i_a_byte = '0;
  logic [W-1:0] i_b_byte = '0;
  logic         i_ready = 1'b0;
  logic         o_ready, o_cin, o_add_sub, o_valid, o_last;
  logic         o_cout, o_ovf, o_zero, o_busy;
  logic [W-1:0] o_a, o_b, o_sum_byte, i_sum;
  logic         i_cout;
  logic [W:0]   add_res;

  int   n_cmp = 0;
  int   n_bad = 0;
  sb_t  exp_q[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  // External adder stage: sum = a + (b ^ mode) + cin.
  assign add_res = {1'b0, o_a} + {1'b0, o_b ^ {W{o_add_sub}}} + {{W{1'b0}}, o_cin};
  assign i_sum   = add_res[W-1:0];
  assign i_cout  = add_res[W];

  addsub_seq_ctrl #(.WIDTH(W), .NBYTES(NB)) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_add_sub  (i_add_sub),
    .i_valid    (i_valid),
    .i_a_byte   (i_a_byte),
    .i_b_byte   (i_b_byte),
    .o_ready    (o_ready),
    .o_a        (o_a),
    .o_b        (o_b),
    .o_cin      (o_cin),
    .o_add_sub  (o_add_sub),
    .i_sum      (i_sum),
    .i_cout     (i_cout),
    .o_valid    (o_valid),
    .o_sum_byte (o_sum_byte),
    .o_last     (o_last),
    .i_ready    (i_ready),
    .o_cout     (o_cout),
    .o_ovf      (o_ovf),
    .o_zero     (o_zero),
    .o_busy     (o_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not occur (expected it to)", name);
  endtask

  task automatic run_op(input vec_t v, input bit stall, input bit noisy_start);
    int  in_idx;
    int  out_cnt;
    int  cyc;
    int  stalls;
    sb_t e;
    // Start cycle also offers byte 0; it must not be taken while still IDLE.
    i_start   = 1'b1;
    i_add_sub = v.mode;
    i_valid   = 1'b1;
    i_a_byte  = v.a[W-1:0];
    i_b_byte  = v.b[W-1:0];
    i_ready   = 1'b1;
    @(negedge clk);
    check("ready_in_idle", o_ready, 1'b0);
    @(posedge clk); #1;
    check("busy_after_start", o_busy, 1'b1);
    i_start   = noisy_start;
    i_add_sub = noisy_start ? ~v.mode : v.mode;
    in_idx  = 0;
    out_cnt = 0;
    cyc     = 0;
    stalls  = 0;
    while (out_cnt < NB && cyc < 100) begin
      i_valid = (in_idx < NB);
      if (in_idx < NB) begin
        i_a_byte = v.a[in_idx*W +: W];
        i_b_byte = v.b[in_idx*W +: W];
      end
      i_ready = 1'b1;
      if (stall && out_cnt == 0 && o_valid && stalls < 3) begin
        i_ready = 1'b0;
        stalls++;
      end
      @(negedge clk);
      if (!i_ready) begin
        check("stall_ready", o_ready, 1'b0);
        if (exp_q.size() == 0) fail_now("stall_sb_entry");
        else check("stall_hold", o_sum_byte, exp_q[0].dat);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("sb_entry");
        end else begin
          e = exp_q.pop_front();
          check("sum_byte", o_sum_byte, e.dat);
          check("last", o_last, e.last);
          if (e.last) begin
            check("cout", o_cout, v.cout);
            check("ovf", o_ovf, FLAGS ? v.ovf : 1'b0);
            check("zero", o_zero, FLAGS ? v.zero : 1'b0);
          end
        end
        out_cnt++;
      end
      if (i_valid && o_ready) begin
        exp_q.push_back('{dat: v.res[in_idx*W +: W], last: (in_idx == NB-1)});
        in_idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_valid = 1'b0;
    i_start = 1'b0;
    if (cyc >= 100) fail_now("op_timeout");
    // Start edge plus NB+1 further edges gives NB+2 cycles from i_start to IDLE.
    if (!stall) check("op_cycles", cyc, NB + 1);
    check("busy_done", o_busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 32'h0102_0304, 32'h1020_3040, 32'h1122_3344, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_ready", o_ready, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_cin", o_cin, 1'b0);
    check("rst_mode", o_add_sub, 1'b0);
    check("rst_outs", {o_sum_byte, o_last, o_cout, o_ovf, o_zero}, '0);
    i_rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i], 1'b0, (i == 5));
    end

    run_op(vecs[8], 1'b1, 1'b0);

    // Abandon a subtract after two accepted bytes.
    i_start   = 1'b1;
    i_add_sub = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_valid  = 1'b1;
      i_a_byte = 8'h11;
      i_b_byte = 8'h22;
      @(negedge clk);
      check("abort_ready", o_ready, 1'b1);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_valid", o_valid, 1'b0);
    check("abort_busy", o_busy, 1'b0);
    check("abort_ready_idle", o_ready, 1'b0);
    check("abort_mode", o_add_sub, 1'b0);
    i_rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    run_op(vecs[7], 1'b0, 1'b0);

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
